// File: rtl/mcycle_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
// Holds the decoded opcode/funct values, ALU command encodings, datapath
// mux select encodings and the control state enumeration.
package mcycle_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_t;

    // Register file destination select
    localparam logic [1:0] REG_DST_RD = 2'd0;
    localparam logic [1:0] REG_DST_RT = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // ALU operand A select
    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_REG = 1'b1;

    // ALU operand B select
    localparam logic [1:0] SRC_B_IMM    = 2'd0;
    localparam logic [1:0] SRC_B_REG    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    // Register write-back data select
    localparam logic [1:0] WB_SRC_ALUOUT = 2'd0;
    localparam logic [1:0] WB_SRC_MEM    = 2'd1;
    localparam logic [1:0] WB_SRC_PC     = 2'd2;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC_R    = 4'd7,
        ST_WB_R      = 4'd8,
        ST_EXEC_I    = 4'd9,
        ST_WB_I      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_JAL       = 4'd13,
        ST_JR        = 4'd14,
        ST_HALT      = 4'd15
    } state_t;

endpackage

// File: rtl/mcycle_alu_decode.sv
// Combinational ALU command decoder.
// Maps opcode/funct to the ALU command used in the execute states.
// Ports:
//   opcode  - IR[31:26]
//   funct   - IR[5:0], only meaningful for R-type
//   alu_cmd - ALU command (ADD for anything without its own operation)
module mcycle_alu_decode
    import mcycle_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_cmd
);

    always_comb begin
        alu_cmd = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_cmd = ALU_SUB;
                FN_SLT:  alu_cmd = ALU_SLT;
                default: alu_cmd = ALU_ADD;
            endcase
        end else if (opcode == OP_XORI) begin
            alu_cmd = ALU_XOR;
        end
    end

endmodule

// File: rtl/mcycle_control_fsm.sv
// Multicycle MIPS-subset control unit. One state per cycle sequences
// fetch, decode, execute, memory and write-back and drives every write
// enable, mux select and ALU command of the datapath.
// Ports:
//   clk, rst_n      - clock (rising edge), async active-low reset
//   opcode, funct   - instruction fields from the IR
//   zero            - ALU zero flag, used in BRANCH only
//   pc_we, mem_we, ir_we, reg_we - datapath write enables
//   reg_dst, alu_src_a, alu_src_b, pc_src, wb_src - mux selects
//   alu_cmd         - ALU operation
//   illegal         - sticky flag, set when an unsupported instruction halts
//   state_o         - current state code for debug
module mcycle_control_fsm
    import mcycle_pkg::*;
#(
    parameter int ADDR_W = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    output logic              pc_we,
    output logic              mem_we,
    output logic              ir_we,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_cmd,
    output logic [1:0]        pc_src,
    output logic [1:0]        wb_src,
    output logic              illegal,
    output logic [ADDR_W-1:0] state_o
);

    state_t     state;
    state_t     next_state;
    logic [2:0] dec_cmd;

    mcycle_alu_decode u_alu_decode (
        .opcode  (opcode),
        .funct   (funct),
        .alu_cmd (dec_cmd)
    );

    // State register plus the sticky illegal flag. The flag is set on the
    // transition into HALT so it is visible in the first HALT cycle, and
    // only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RST;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == ST_HALT) begin
                illegal <= 1'b1;
            end
        end
    end

    // Next-state and Moore outputs. Everything defaults to idle/ADD so each
    // state only lists what it asserts. opcode/funct are consulted only in
    // DECODE, MEM_ADDR and the execute states, where the IR is stable.
    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_IMM;
        alu_cmd    = ALU_ADD;
        pc_src     = PC_SRC_ALU;
        wb_src     = WB_SRC_ALUOUT;

        case (state)
            ST_RST: next_state = ST_FETCH;

            ST_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                next_state = ST_DECODE;
            end

            // The ALU speculatively computes the branch target into ALUout
            // while the opcode is being decoded.
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW:     next_state = ST_MEM_ADDR;
                    OP_ADDI, OP_XORI: next_state = ST_EXEC_I;
                    OP_BNE:           next_state = ST_BRANCH;
                    OP_J:             next_state = ST_JUMP;
                    OP_JAL:           next_state = ST_JAL;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_SLT: next_state = ST_EXEC_R;
                            FN_JR:                  next_state = ST_JR;
                            default:                next_state = ST_HALT;
                        endcase
                    end
                    default: next_state = ST_HALT;
                endcase
            end

            ST_MEM_ADDR: begin
                alu_src_a  = SRC_A_REG;
                next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end

            ST_MEM_READ: next_state = ST_MEM_WB;

            ST_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RT;
                wb_src     = WB_SRC_MEM;
                next_state = ST_FETCH;
            end

            ST_MEM_WRITE: begin
                mem_we     = 1'b1;
                next_state = ST_FETCH;
            end

            ST_EXEC_R: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                alu_cmd    = dec_cmd;
                next_state = ST_WB_R;
            end

            ST_WB_R: begin
                reg_we     = 1'b1;
                next_state = ST_FETCH;
            end

            ST_EXEC_I: begin
                alu_src_a  = SRC_A_REG;
                alu_cmd    = dec_cmd;
                next_state = ST_WB_I;
            end

            ST_WB_I: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RT;
                next_state = ST_FETCH;
            end

            // BNE: the only output depending on an input. The PC loads the
            // target held in ALUout when the operands differ.
            ST_BRANCH: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                alu_cmd    = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_we      = ~zero;
                next_state = ST_FETCH;
            end

            ST_JUMP: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_JUMP;
                next_state = ST_FETCH;
            end

            // The PC already holds PC+4 from FETCH, which is the link value.
            ST_JAL: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RA;
                wb_src     = WB_SRC_PC;
                pc_we      = 1'b1;
                pc_src     = PC_SRC_JUMP;
                next_state = ST_FETCH;
            end

            ST_JR: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_REG;
                next_state = ST_FETCH;
            end

            ST_HALT: next_state = ST_HALT;

            default: next_state = ST_RST;
        endcase
    end

    assign state_o = ADDR_W'(state);

endmodule

// File: tb/tb_mcycle_control_fsm.sv
// Self-checking bench for mcycle_control_fsm. A reference model built from
// the per-instruction state paths and per-state output rows predicts every
// cycle; stimulus mixes directed instructions with random ones.
module tb_mcycle_control_fsm;
    import mcycle_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we, mem_we, ir_we, reg_we, alu_src_a, illegal;
    logic [1:0] reg_dst, alu_src_b, pc_src, wb_src;
    logic [2:0] alu_cmd;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_we;
        logic       mem_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_cmd;
        logic [1:0] pc_src;
        logic [1:0] wb_src;
        logic       illegal;
    } obs_t;

    mcycle_control_fsm #(.ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .pc_we     (pc_we),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_cmd   (alu_cmd),
        .pc_src    (pc_src),
        .wb_src    (wb_src),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t observe();
        return {state_o, pc_we, mem_we, ir_we, reg_we, reg_dst, alu_src_a,
                alu_src_b, alu_cmd, pc_src, wb_src, illegal};
    endfunction

    // Expected state path of one instruction starting at FETCH.
    task automatic get_path(input logic [5:0] op, input logic [5:0] fn,
                            output state_t p [6], output int n);
        for (int i = 0; i < 6; i++) p[i] = ST_HALT;
        p[0] = ST_FETCH;
        p[1] = ST_DECODE;
        n = 3;
        case (op)
            6'h23: begin p[2] = ST_MEM_ADDR; p[3] = ST_MEM_READ; p[4] = ST_MEM_WB; n = 5; end
            6'h2B: begin p[2] = ST_MEM_ADDR; p[3] = ST_MEM_WRITE; n = 4; end
            6'h08, 6'h0E: begin p[2] = ST_EXEC_I; p[3] = ST_WB_I; n = 4; end
            6'h05: p[2] = ST_BRANCH;
            6'h02: p[2] = ST_JUMP;
            6'h03: p[2] = ST_JAL;
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin
                    p[2] = ST_EXEC_R; p[3] = ST_WB_R; n = 4;
                end else if (fn == 6'h08) begin
                    p[2] = ST_JR;
                end else begin
                    p[2] = ST_HALT;
                end
            end
            default: p[2] = ST_HALT;
        endcase
    endtask

    // Expected outputs for one cycle, written straight from the state table.
    function automatic obs_t exp_out(state_t s, logic [5:0] op, logic [5:0] fn, logic z);
        obs_t e = '0;
        e.state = 4'(s);
        case (s)
            ST_FETCH:     begin e.ir_we = 1; e.pc_we = 1; e.src_b = 2; end
            ST_DECODE:    e.src_b = 3;
            ST_MEM_ADDR:  e.src_a = 1;
            ST_MEM_WB:    begin e.reg_we = 1; e.reg_dst = 1; e.wb_src = 1; end
            ST_MEM_WRITE: e.mem_we = 1;
            ST_EXEC_R: begin
                e.src_a = 1; e.src_b = 1;
                e.alu_cmd = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
            end
            ST_WB_R:      e.reg_we = 1;
            ST_EXEC_I:    begin e.src_a = 1; e.alu_cmd = (op == 6'h0E) ? 3'd2 : 3'd0; end
            ST_WB_I:      begin e.reg_we = 1; e.reg_dst = 1; end
            ST_BRANCH:    begin e.src_a = 1; e.src_b = 1; e.alu_cmd = 1; e.pc_src = 1; e.pc_we = ~z; end
            ST_JUMP:      begin e.pc_we = 1; e.pc_src = 2; end
            ST_JAL:       begin e.reg_we = 1; e.reg_dst = 2; e.wb_src = 2; e.pc_we = 1; e.pc_src = 2; end
            ST_JR:        begin e.pc_we = 1; e.pc_src = 3; end
            ST_HALT:      e.illegal = 1;
            default:      ;
        endcase
        return e;
    endfunction

    task automatic test_reset();
        obs_t act, exp;
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        repeat (2) @(negedge clk);
        act = observe(); exp = exp_out(ST_RST, 6'h00, 6'h00, 1'b0);
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL reset_held: got %h expected %h", act, exp); end
        rst_n = 1'b1;
        #1;
        act = observe();
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL reset_release: got %h expected %h", act, exp); end
        @(negedge clk);
        #1;
        act = observe(); exp = exp_out(ST_FETCH, 6'h00, 6'h00, 1'b0);
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL first_fetch: got %h expected %h", act, exp); end
        @(negedge clk);
        // Reset landed on the negedge; re-enter FETCH cleanly for the next tests.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        state_t p [6]; int n; obs_t act, exp;
        get_path(6'h23, 6'h00, p, n);
        for (int k = 0; k < n; k++) begin
            opcode = (k == 0) ? 6'($urandom) : 6'h23;
            funct  = 6'($urandom);
            zero   = 1'($urandom);
            #1;
            act = observe(); exp = exp_out(p[k], 6'h23, funct, zero);
            checks++;
            if (act !== exp) begin errors++; $display("[TB] FAIL lw step %0d: got %h expected %h", k, act, exp); end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'(ST_FETCH)) begin errors++; $display("[TB] FAIL lw_return: got %0d expected %0d", state_o, 1); end
        @(negedge clk);
        // That check consumed a FETCH cycle; drain the rest of a dummy instruction.
        opcode = 6'h02; repeat (2) @(negedge clk);
    endtask

    task automatic test_r_type();
        logic [5:0] fns [4] = '{6'h22, 6'h20, 6'h2A, 6'h08};
        state_t p [6]; int n; obs_t act, exp;
        for (int i = 0; i < 4; i++) begin
            get_path(6'h00, fns[i], p, n);
            for (int k = 0; k < n; k++) begin
                opcode = (k == 0) ? 6'($urandom) : 6'h00;
                funct  = (k == 0) ? 6'($urandom) : fns[i];
                zero   = 1'($urandom);
                #1;
                act = observe(); exp = exp_out(p[k], 6'h00, fns[i], zero);
                checks++;
                if (act !== exp) begin errors++; $display("[TB] FAIL rtype fn=%h step %0d: got %h expected %h", fns[i], k, act, exp); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch();
        state_t p [6]; int n; obs_t act, exp;
        for (int z = 0; z < 2; z++) begin
            get_path(6'h05, 6'h00, p, n);
            for (int k = 0; k <= n; k++) begin
                opcode = (k == 0) ? 6'($urandom) : 6'h05;
                funct  = 6'($urandom);
                zero   = 1'(z);
                #1;
                act = observe();
                exp = exp_out((k == n) ? ST_FETCH : p[k], 6'h05, funct, zero);
                checks++;
                if (act !== exp) begin errors++; $display("[TB] FAIL bne zero=%0d step %0d: got %h expected %h", z, k, act, exp); end
                if (k < n) @(negedge clk);
            end
        end
    endtask

    task automatic test_jumps_and_imm();
        logic [5:0] ops [5] = '{6'h03, 6'h0E, 6'h08, 6'h02, 6'h2B};
        state_t p [6]; int n; obs_t act, exp;
        for (int i = 0; i < 5; i++) begin
            get_path(ops[i], 6'h00, p, n);
            for (int k = 0; k < n; k++) begin
                opcode = (k == 0) ? 6'($urandom) : ops[i];
                funct  = 6'($urandom);
                zero   = 1'($urandom);
                #1;
                act = observe(); exp = exp_out(p[k], ops[i], funct, zero);
                checks++;
                if (act !== exp) begin errors++; $display("[TB] FAIL op=%h step %0d: got %h expected %h", ops[i], k, act, exp); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] legal [11] = '{12'h8C0, 12'hAC0, 12'h080, 12'h0C0, 12'h140, 12'h200,
                                    12'h380, 12'h020, 12'h022, 12'h02A, 12'h008};
        logic [11:0] pick;
        logic [5:0] op, fn;
        state_t p [6]; int n; obs_t act, exp;
        for (int i = 0; i < 60; i++) begin
            pick = legal[$urandom_range(0, 10)];
            op = pick[11:6];
            fn = (op == 6'h00) ? pick[5:0] : 6'($urandom);
            get_path(op, fn, p, n);
            for (int k = 0; k < n; k++) begin
                opcode = (k == 0) ? 6'($urandom) : op;
                funct  = (k == 0) ? 6'($urandom) : fn;
                zero   = 1'($urandom);
                #1;
                act = observe(); exp = exp_out(p[k], op, fn, zero);
                checks++;
                if (act !== exp) begin errors++; $display("[TB] FAIL random #%0d op=%h fn=%h step %0d: got %h expected %h", i, op, fn, k, act, exp); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad [2] = '{12'hFC0, 12'h03F};
        logic [11:0] pick;
        state_t p [6]; int n; obs_t act, exp;
        for (int i = 0; i < 2; i++) begin
            pick = bad[i];
            get_path(pick[11:6], pick[5:0], p, n);
            for (int k = 0; k < n + 10; k++) begin
                opcode = (k == 0) ? 6'($urandom) : (k < 2) ? pick[11:6] : 6'($urandom);
                funct  = (k == 0) ? 6'($urandom) : (k < 2) ? pick[5:0]  : 6'($urandom);
                zero   = 1'($urandom);
                #1;
                act = observe();
                exp = exp_out((k < n) ? p[k] : ST_HALT, pick[11:6], pick[5:0], zero);
                checks++;
                if (act !== exp) begin errors++; $display("[TB] FAIL illegal %h step %0d: got %h expected %h", pick, k, act, exp); end
                @(negedge clk);
            end
            rst_n = 1'b0;
            #1;
            act = observe(); exp = exp_out(ST_RST, 6'h00, 6'h00, 1'b0);
            checks++;
            if (act !== exp) begin errors++; $display("[TB] FAIL illegal_clear: got %h expected %h", act, exp); end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'(ST_FETCH)) begin errors++; $display("[TB] FAIL illegal_restart: got %0d expected 1", state_o); end
            #1;
            // Finish this FETCH with a jump so the next round starts at FETCH.
            opcode = 6'h02; funct = '0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        state_t p [6]; int n; obs_t act, exp;
        get_path(6'h2B, 6'h00, p, n);
        for (int k = 0; k < 3; k++) begin
            opcode = (k == 0) ? 6'($urandom) : 6'h2B;
            funct  = 6'($urandom);
            zero   = 1'($urandom);
            #1;
            act = observe(); exp = exp_out(p[k], 6'h2B, funct, zero);
            checks++;
            if (act !== exp) begin errors++; $display("[TB] FAIL sw_pre_reset step %0d: got %h expected %h", k, act, exp); end
            if (k < 2) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        act = observe(); exp = exp_out(ST_RST, 6'h00, 6'h00, 1'b0);
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL async_reset: got %h expected %h", act, exp); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_we !== 1'b0 || state_o !== 4'd0) begin
                errors++; $display("[TB] FAIL reset_hold cycle %0d: got mem_we=%b state=%0d expected 0/0", c, mem_we, state_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        act = observe(); exp = exp_out(ST_FETCH, 6'h00, 6'h00, 1'b0);
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL post_reset_fetch: got %h expected %h", act, exp); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_type();
        test_branch();
        test_jumps_and_imm();
        test_random();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
